// File: rtl/mem_ring_ctrl.sv
// mem_ring_ctrl
//   Ring-side access controller in front of memory port B. Accepts one word
//   read/write request per cycle from the ring, drives the port B strobes
//   combinationally in the accept cycle, captures the one-cycle-latency read
//   data and returns ordered read responses through a small FIFO. Request
//   acceptance reserves a FIFO slot for every read in flight, so read data is
//   never dropped when the ring back-pressures responses.
//
// Ports
//   clock, rst          : clock and synchronous active-high reset
//   req_valid/ready     : request handshake
//   req_opcode          : 2'b01 RD, 2'b10 WR, others illegal (consumed, flagged)
//   req_address/data/tag: word address, write data, requestor tag
//   rsp_valid/ready     : read response handshake
//   rsp_address/data/tag: returned word, its address and originating tag
//   mem_address_b, mem_data_b, mem_rden_b, mem_wren_b, mem_q_b : memory port B
//   rd_cnt, wr_cnt      : saturating counts of accepted RD / WR requests
//   err_illegal         : sticky, set when an illegal opcode is accepted
module mem_ring_ctrl #(
    parameter int MSB_MEM   = 7,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_opcode,
    input  logic [MSB_MEM:2]     req_address,
    input  logic [31:0]          req_data,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MSB_MEM:2]     rsp_address,
    output logic [31:0]          rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [MSB_MEM:2]     mem_address_b,
    output logic [31:0]          mem_data_b,
    output logic                 mem_rden_b,
    output logic                 mem_wren_b,
    input  logic [31:0]          mem_q_b,
    output logic [15:0]          rd_cnt,
    output logic [15:0]          wr_cnt,
    output logic                 err_illegal
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(RSP_DEPTH);

    typedef struct packed {
        logic [MSB_MEM:2]   addr;
        logic [31:0]        data;
        logic [TAG_W-1:0]   tag;
    } rsp_t;

    localparam rsp_t RSP_ZERO = '0;

    rsp_t              fifo_mem [RSP_DEPTH];
    rsp_t              head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic [PW+1:0]     occupancy;
    logic              rd_inflight;
    logic [MSB_MEM:2]  rd_addr_p1;
    logic [TAG_W-1:0]  rd_tag_p1;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              ill_acc;
    logic              push;
    logic              pop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) return v + 16'd1;
        return v;
    endfunction

    // Queued responses plus the read still in flight; each holds a FIFO slot.
    assign occupancy = {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, rd_inflight};
    assign req_ready = !rst && (occupancy < DEPTH_C);

    assign accept  = req_valid && req_ready;
    assign rd_acc  = accept && (req_opcode == 2'b01);
    assign wr_acc  = accept && (req_opcode == 2'b10);
    assign ill_acc = accept && ((req_opcode == 2'b00) || (req_opcode == 2'b11));

    assign push      = rd_inflight;
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Stage p0: port B strobes in the accept cycle. Address/data are parked
    // at zero when idle so nothing toggles on an unused port.
    always_comb begin
        mem_rden_b    = rd_acc;
        mem_wren_b    = wr_acc;
        mem_address_b = '0;
        mem_data_b    = '0;
        if (rd_acc || wr_acc) mem_address_b = req_address;
        if (wr_acc)           mem_data_b    = req_data;
    end

    // Stage p1: read in flight; capture address/tag beside the memory read.
    always_ff @(posedge clock) begin
        if (rd_acc) begin
            rd_addr_p1 <= req_address;
            rd_tag_p1  <= req_tag;
        end
        if (push) fifo_mem[wr_ptr] <= '{addr: rd_addr_p1, data: mem_q_b, tag: rd_tag_p1};
    end

    // Stage p2: response FIFO control, counters and error flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_inflight <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            err_illegal <= 1'b0;
        end else begin
            rd_inflight <= rd_acc;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            rd_cnt      <= sat_inc(rd_cnt, rd_acc);
            wr_cnt      <= sat_inc(wr_cnt, wr_acc);
            err_illegal <= err_illegal | ill_acc;
        end
    end

    // Present zeros while empty so the response fields are clean after reset.
    assign head        = rsp_valid ? fifo_mem[rd_ptr] : RSP_ZERO;
    assign rsp_address = head.addr;
    assign rsp_data    = head.data;
    assign rsp_tag     = head.tag;

endmodule

// File: tb/tb_mem_ring_ctrl.sv
// tb_mem_ring_ctrl
//   Self-checking bench for mem_ring_ctrl. A behavioral port-B memory feeds
//   mem_q_b. A negedge monitor predicts acceptance from a transaction model,
//   pushes expected read responses into a scoreboard queue and pops/compares
//   them as the DUT presents them. Scenario tasks run in sequence.
module tb_mem_ring_ctrl;

    localparam int MSB_MEM   = 7;
    localparam int RSP_DEPTH = 4;
    localparam int TAG_W     = 8;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_opcode;
    logic [MSB_MEM:2]  req_address;
    logic [31:0]       req_data;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [MSB_MEM:2]  rsp_address;
    logic [31:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic [MSB_MEM:2]  mem_address_b;
    logic [31:0]       mem_data_b;
    logic              mem_rden_b;
    logic              mem_wren_b;
    logic [31:0]       mem_q_b;
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;
    logic              err_illegal;

    mem_ring_ctrl #(.MSB_MEM(MSB_MEM), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_address(req_address), .req_data(req_data), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_address(rsp_address),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mem_address_b(mem_address_b), .mem_data_b(mem_data_b),
        .mem_rden_b(mem_rden_b), .mem_wren_b(mem_wren_b), .mem_q_b(mem_q_b),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_illegal(err_illegal)
    );

    typedef struct {
        logic [MSB_MEM:2] a;
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        int               acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rsp_seen = 0;
    logic [15:0] m_rd, m_wr;
    logic        m_err;
    logic        exp_ready, acc, erd, ewr;
    exp_t        e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioral port-B memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wren_b) mem[mem_address_b] <= mem_data_b;
        if (mem_rden_b) mem_q_b <= mem[mem_address_b];
    end

    // Transaction monitor and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_rd = '0; m_wr = '0; m_err = 1'b0;
        end else begin
            exp_ready = (sb.size() < RSP_DEPTH);
            n_tests++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL req_ready @%0d: got %b want %b", cyc, req_ready, exp_ready);
            end
            acc = req_valid && exp_ready;
            erd = acc && (req_opcode == 2'b01);
            ewr = acc && (req_opcode == 2'b10);
            n_tests++;
            if (mem_rden_b !== erd || mem_wren_b !== ewr) begin
                n_fail++; $display("FAIL strobes @%0d: got rd=%b wr=%b want rd=%b wr=%b", cyc, mem_rden_b, mem_wren_b, erd, ewr);
            end
            if (erd || ewr) begin
                n_tests++;
                if (mem_address_b !== req_address) begin
                    n_fail++; $display("FAIL mem_address_b @%0d: got %h want %h", cyc, mem_address_b, req_address);
                end
            end
            if (ewr) begin
                n_tests++;
                if (mem_data_b !== req_data) begin
                    n_fail++; $display("FAIL mem_data_b @%0d: got %h want %h", cyc, mem_data_b, req_data);
                end
                ref_mem[req_address] = req_data;
            end
            n_tests++;
            if (rd_cnt !== m_rd || wr_cnt !== m_wr || err_illegal !== m_err) begin
                n_fail++; $display("FAIL counters @%0d: got rd=%h wr=%h err=%b want rd=%h wr=%h err=%b", cyc, rd_cnt, wr_cnt, err_illegal, m_rd, m_wr, m_err);
            end
            if (rsp_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rsp_unexpected @%0d: got addr=%h data=%h tag=%h want no response", cyc, rsp_address, rsp_data, rsp_tag);
                end else if (cyc - sb[0].acc < 2) begin
                    n_fail++; $display("FAIL rsp_early @%0d: got latency %0d want >=2", cyc, cyc - sb[0].acc);
                end else if (rsp_address !== sb[0].a || rsp_data !== sb[0].d || rsp_tag !== sb[0].t) begin
                    n_fail++; $display("FAIL rsp_fields @%0d: got %h/%h/%h want %h/%h/%h", cyc, rsp_address, rsp_data, rsp_tag, sb[0].a, sb[0].d, sb[0].t);
                end
                if (rsp_ready && sb.size() != 0) begin
                    void'(sb.pop_front());
                    rsp_seen++;
                end
            end else if (sb.size() != 0 && cyc - sb[0].acc >= 2) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_missing @%0d: got rsp_valid=%b want 1 for tag %h", cyc, rsp_valid, sb[0].t);
            end
            if (erd) begin
                e.a = req_address; e.d = ref_mem[req_address]; e.t = req_tag; e.acc = cyc;
                sb.push_back(e);
            end
            if (erd && m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
            if (ewr && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            if (acc && (req_opcode == 2'b00 || req_opcode == 2'b11)) m_err = 1'b1;
        end
    end

    // Present one request from posedge+1 and hold it until accepted.
    task automatic send(input logic [1:0] op, input logic [MSB_MEM:2] a,
                        input logic [31:0] d, input logic [TAG_W-1:0] t, input int max_wait);
        bit got = 0;
        req_valid = 1'b1; req_opcode = op; req_address = a; req_data = d; req_tag = t;
        for (int w = 0; w < max_wait && !got; w++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL accept_timeout: got no accept in %0d cycles want accept of addr %h", max_wait, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_opcode = 2'b00; req_address = '0;
        req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_rden_b !== 1'b0 || mem_wren_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got ready=%b valid=%b rd=%b wr=%b want 0000", req_ready, rsp_valid, mem_rden_b, mem_wren_b);
        end
        n_tests++;
        if (rsp_address !== '0 || rsp_data !== '0 || rsp_tag !== '0 || mem_address_b !== '0 || mem_data_b !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h %h want all 0", rsp_address, rsp_data, rsp_tag, mem_address_b, mem_data_b);
        end
        n_tests++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0 || err_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: got rd=%h wr=%h err=%b want 0 0 0", rd_cnt, wr_cnt, err_illegal);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_readback();
        rsp_ready = 1'b1;
        send(2'b10, 6'h05, 32'hDEADBEEF, 8'h11, 1);
        send(2'b01, 6'h05, 32'h0, 8'h22, 1);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rb_t2: got rsp_valid=%b want 0", rsp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_tag !== 8'h22 || rsp_address !== 6'h05) begin
            n_fail++; $display("FAIL rb_t3: got v=%b d=%h t=%h a=%h want 1 deadbeef 22 05", rsp_valid, rsp_data, rsp_tag, rsp_address);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        int seen0 = rsp_seen;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b01, 6'(i), 32'h0, 8'(8'h40 + i), 1);
        req_valid = 1'b1; req_opcode = 2'b01; req_address = 6'h04; req_tag = 8'h44;
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready: got %b want 0", req_ready);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_address !== 6'h00 || rsp_seen != seen0) begin
            n_fail++; $display("FAIL bp_head: got v=%b a=%h popped=%0d want 1 00 0", rsp_valid, rsp_address, rsp_seen - seen0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(2'b01, 6'h04, 32'h0, 8'h44, 8);
        send(2'b01, 6'h05, 32'h0, 8'h45, 8);
        for (int w = 0; w < 12 && sb.size() != 0; w++) begin @(posedge clk); #1; end
        n_tests++;
        if (rsp_seen - seen0 != 6 || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: got %0d responses (%0d pending) want 6", rsp_seen - seen0, sb.size());
        end
    endtask

    task automatic test_streaming();
        int seen0 = rsp_seen;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(2'b01, 6'(i + 10), 32'h0, 8'(i), 1);
        for (int w = 0; w < 8 && sb.size() != 0; w++) begin @(posedge clk); #1; end
        n_tests++;
        if (rsp_seen - seen0 != 20 || sb.size() != 0) begin
            n_fail++; $display("FAIL stream_count: got %0d want 20", rsp_seen - seen0);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] rd0 = m_rd;
        logic [15:0] wr0 = m_wr;
        n_tests++;
        if (err_illegal !== 1'b0) begin
            n_fail++; $display("FAIL err_before: got %b want 0", err_illegal);
        end
        send(2'b11, 6'h07, 32'h12345678, 8'h77, 1);
        send(2'b00, 6'h08, 32'h0, 8'h78, 1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_tests++;
        if (err_illegal !== 1'b1 || rd_cnt !== rd0 || wr_cnt !== wr0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL illegal: got err=%b rd=%h wr=%h v=%b want 1 %h %h 0", err_illegal, rd_cnt, wr_cnt, rsp_valid, rd0, wr0);
        end
        @(posedge clk); #1;
        send(2'b01, 6'h07, 32'h0, 8'h79, 1);
        repeat (4) begin @(posedge clk); #1; end
        n_tests++;
        if (err_illegal !== 1'b1 || mem[7] !== ref_mem[7]) begin
            n_fail++; $display("FAIL err_sticky: got err=%b mem7=%h want 1 %h", err_illegal, mem[7], ref_mem[7]);
        end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b01, 6'(i + 30), 32'h0, 8'(8'h90 + i), 1);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_rden_b !== 1'b0 || mem_wren_b !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_cycle: got rd=%b wr=%b ready=%b want 000", mem_rden_b, mem_wren_b, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0 || req_ready !== 1'b1 || err_illegal !== 1'b0) begin
            n_fail++; $display("FAIL after_rst: got v=%b rd=%h wr=%h ready=%b err=%b want 0 0 0 1 0", rsp_valid, rd_cnt, wr_cnt, req_ready, err_illegal);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_counter_saturation();
        for (int i = 0; i < 65534; i++) send(2'b10, 6'(i), 32'(i) ^ 32'hC0DE0000, 8'h00, 1);
        @(negedge clk);
        n_tests++;
        if (wr_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL wr_cnt_near: got %h want fffe", wr_cnt);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(2'b10, 6'(i), 32'hA0A0A0A0, 8'h00, 1);
        @(negedge clk);
        n_tests++;
        if (wr_cnt !== 16'hFFFF || rd_cnt !== 16'h0) begin
            n_fail++; $display("FAIL wr_cnt_sat: got wr=%h rd=%h want ffff 0000", wr_cnt, rd_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA5000000 | 32'(i);
            ref_mem[i] = 32'hA5000000 | 32'(i);
        end
        test_reset();
        test_write_readback();
        test_back_pressure();
        test_streaming();
        test_illegal();
        test_reset_midflight();
        test_counter_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion by %0t want finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
